audio_manip: RTL and testbench
==============================

Name: audio_manip

Overview:
- Stereo 24-bit record/playback buffer between the codec sample interface and downstream audio processing.
- On a write trigger, it captures a fixed-length block of left/right samples into internal RAM.
- On a read trigger, it plays the stored block back in a continuous loop, paced by the sample strobe and a downstream ready.
- Exports status flags and the current buffer pointer for debug/display.

Parameters:
- DATA_W, 24, sample width per channel.
- ADDR_W, 7, buffer address width; DEPTH = 2**ADDR_W (default 128). Legal range 1..7.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start_write  in  1  record trigger; level, sampled each clk.
- start_read  in  1  playback request; level, playback runs while high.
- new_sample  in  1  codec sample strobe; one sample per 0->1 transition.
- readySignal  in  1  downstream ready; playback advances only when high.
- in_l  in  24  left input sample.
- in_r  in  24  right input sample.
- out_l  out  24  left output sample, registered.
- out_r  out  24  right output sample, registered.
- writeComplete  out  1  sticky: buffer fully recorded.
- some_data  out  7  current pointer, zero-extended to 7 bits.
- signalA  out  1  high while in WRITE.
- signalB  out  1  high while in READ.

Behaviour:
- Sample event (sev): new_sample==1 and the registered previous value of new_sample==0. This gives one event per rising edge. The previous-value register resets to 0.
- Reset: all of the following are cleared to 0.
  - state=IDLE, ptr=0
  - out_l=0, out_r=0
  - writeComplete=0, signalA=0, signalB=0
  - RAM contents are not cleared.
- Reset applied mid-operation aborts immediately to IDLE and clears writeComplete.
- IDLE:
  - start_write -> WRITE, ptr<=0, writeComplete<=0.
  - Otherwise, start_read with writeComplete==1 -> READ, ptr<=0.
  - start_write has priority over start_read when both are high.
- WRITE:
  - On each sev: mem[ptr] <= {in_l,in_r}, ptr<=ptr+1.
  - On the sev that writes address DEPTH-1: ptr<=0, writeComplete<=1, state->DONE.
  - A recording, once started, always completes; start_write deassertion and start_read are both ignored during WRITE.
- DONE:
  - start_write -> WRITE (re-record, writeComplete<=0).
  - Else start_read -> READ, ptr<=0.
- READ:
  - On each sev with readySignal==1: fetch mem[ptr], ptr<=ptr+1 with wrap DEPTH-1 -> 0 (loop playback).
  - Read data appears on out_l/out_r exactly 2 clk edges after the edge ending the accepting cycle (sync RAM read + output register).
  - sev with readySignal==0: dropped; ptr and out are unchanged.
  - start_read==0 -> DONE. Outputs hold their last value; an in-flight fetch still lands.
  - start_write -> WRITE (priority over continuing playback).
- out_l/out_r hold their value whenever they are not being updated.
- out_l/out_r are never a pass-through of the inputs unless MONITOR_EN is defined (see Optional Feature).
- some_data = ptr zero-extended to 7 bits, combinational from the registered ptr.
- signalA/signalB are decoded from the registered state; they are never high simultaneously.

Optional Feature:
- Macro: AUDIO_MANIP_MONITOR_EN.
- With it defined: in WRITE, on each sev, out_l<=in_l and out_r<=in_r, one cycle after the sev (live monitoring while recording).
- Without it: outputs hold their value during WRITE.

Decomposition:
- Shared package audio_pkg holds:
  - DATA_W default
  - state enum (IDLE, WRITE, DONE, READ)
  - typedef for the stereo sample struct {left,right}.
- One natural sub-module: audio_buf_ram, a single-port synchronous RAM of DEPTH x 2*DATA_W with registered read.
- Edge detect and FSM stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles mid-WRITE -> all outputs 0, state IDLE, writeComplete 0.
- Record: start_write=1, new_sample toggling every clk, in_l=in_r incrementing from 0 -> signalA=1; some_data counts 0..127; writeComplete rises on the 128th sev; signalA then falls.
- Early request: start_read raised during WRITE -> ignored; READ entered only after writeComplete, then signalB=1.
- Stalled playback: READ with readySignal=0 for 50 sevs -> some_data stays 0 and out_l/out_r unchanged.
- Playback: set readySignal=1 -> out_l/out_r reproduce the recorded sequence in order from address 0 with 2-clk latency; after address 127, wraps to 0 and repeats.
- Simultaneous triggers: start_write and start_read both high in IDLE -> enters WRITE; drop start_read during READ -> DONE, outputs hold.

Source files
------------

// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio record/playback buffer.
//   DEF_DATA_W : default per-channel sample width
//   state_t    : buffer controller states
//   stereo_t   : one stereo sample as stored in the buffer RAM
// ----------------------------------------------------------------------------
package audio_pkg;

   localparam int DEF_DATA_W = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      READ  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] left;
      logic [DEF_DATA_W-1:0] right;
   } stereo_t;

endpackage

// File: rtl/audio_buf_ram.sv
// ----------------------------------------------------------------------------
// audio_buf_ram
// Single-port synchronous RAM, 2**ADDR_W words of WORD_W bits, registered read
// (read-before-write on the same address). Contents are never reset.
// Ports:
//   clk   : clock
//   we    : write enable
//   addr  : word address (shared by read and write)
//   wdata : write word
//   rdata : registered read word, mem[addr] from the previous cycle
// ----------------------------------------------------------------------------
module audio_buf_ram #(
   parameter int ADDR_W = 7,
   parameter int WORD_W = 48
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/audio_manip.sv
// ----------------------------------------------------------------------------
// audio_manip
// Stereo record/playback buffer. A write trigger records 2**ADDR_W stereo
// samples (one per rising edge of new_sample) into the buffer RAM; a held
// read request then loops the recorded block back out, one sample per sample
// strobe while readySignal is high.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_write       : record trigger (level)
//   start_read        : playback request, playback runs while high
//   new_sample        : codec sample strobe, one sample per 0->1 transition
//   readySignal       : downstream ready, gates playback advance
//   in_l, in_r        : input samples
//   out_l, out_r      : registered output samples
//   writeComplete     : sticky, buffer fully recorded
//   some_data         : current buffer pointer, zero-extended to 7 bits
//   signalA / signalB : in WRITE / in READ
//
// Build option: define AUDIO_MANIP_MONITOR_EN to copy the live input to the
// outputs on every sample event while recording.
// ----------------------------------------------------------------------------
module audio_manip
   import audio_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_write,
   input  logic              start_read,
   input  logic              new_sample,
   input  logic              readySignal,
   input  logic [DATA_W-1:0] in_l,
   input  logic [DATA_W-1:0] in_r,
   output logic [DATA_W-1:0] out_l,
   output logic [DATA_W-1:0] out_r,
   output logic              writeComplete,
   output logic [6:0]        some_data,
   output logic              signalA,
   output logic              signalB
);

   localparam logic [ADDR_W-1:0] PTR_LAST = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic              wc_nxt;
   logic              new_sample_q;
   logic              sev;
   logic              mem_we;
   logic              fetch;

   logic              vld_p0, vld_p1;
   logic [ADDR_W-1:0] addr_p0;
   logic [ADDR_W-1:0] ram_addr;
   stereo_t           wr_word, rd_word;

   // One event per rising edge of the codec strobe.
   assign sev = new_sample & ~new_sample_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         new_sample_q  <= 1'b0;
         state         <= IDLE;
         ptr           <= '0;
         writeComplete <= 1'b0;
      end else begin
         new_sample_q  <= new_sample;
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         writeComplete <= wc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      wc_nxt    = writeComplete;
      mem_we    = 1'b0;
      fetch     = 1'b0;
      case (state)
         IDLE: begin
            if (start_write) begin
               state_nxt = WRITE;
               ptr_nxt   = '0;
               wc_nxt    = 1'b0;
            end else if (start_read && writeComplete) begin
               state_nxt = READ;
               ptr_nxt   = '0;
            end
         end
         WRITE: begin
            // Triggers are ignored here: a recording always runs to the end.
            if (sev) begin
               mem_we  = 1'b1;
               ptr_nxt = ptr + PTR_ONE;
               if (ptr == PTR_LAST) begin
                  ptr_nxt   = '0;
                  wc_nxt    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (start_write) begin
               state_nxt = WRITE;
               ptr_nxt   = '0;
               wc_nxt    = 1'b0;
            end else if (start_read) begin
               state_nxt = READ;
               ptr_nxt   = '0;
            end
         end
         READ: begin
            if (start_write) begin
               state_nxt = WRITE;
               ptr_nxt   = '0;
               wc_nxt    = 1'b0;
            end else if (!start_read) begin
               state_nxt = DONE;
            end else if (sev && readySignal) begin
               // Pointer wraps naturally, giving loop playback.
               fetch   = 1'b1;
               ptr_nxt = ptr + PTR_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Writes use the live pointer; reads use the address captured at accept.
   // Sample events are at least two cycles apart, so a write never lands in
   // the cycle a captured read address is presented.
   assign ram_addr      = mem_we ? ptr : addr_p0;
   assign wr_word.left  = in_l;
   assign wr_word.right = in_r;

   audio_buf_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (2 * DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (mem_we),
      .addr  (ram_addr),
      .wdata (wr_word),
      .rdata (rd_word)
   );

   // Stage p0: capture accepted read address
   always_ff @(posedge clk) begin
      addr_p0 <= ptr;
   end

   // Stage p1: synchronous RAM read; stage p2: output register
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= fetch;
         vld_p1 <= vld_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_l <= '0;
         out_r <= '0;
      end
`ifdef AUDIO_MANIP_MONITOR_EN
      else if (state == WRITE && sev) begin
         out_l <= in_l;
         out_r <= in_r;
      end
`endif
      else if (vld_p1) begin
         out_l <= rd_word.left;
         out_r <= rd_word.right;
      end
   end

   always_comb begin
      some_data             = '0;
      some_data[ADDR_W-1:0] = ptr;
   end

   assign signalA = (state == WRITE);
   assign signalB = (state == READ);

endmodule

// File: tb/tb_audio_manip.sv
// ----------------------------------------------------------------------------
// tb_audio_manip
// Directed bench for audio_manip: reset mid-record, full record with both
// triggers raised, stalled playback, looping playback with exact latency,
// drop of the read request, and re-record from DONE.
// Recorded sample i: in_l = i + 1, in_r = 24'h800000 | i.
// ----------------------------------------------------------------------------
module tb_audio_manip;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_write;
   logic        start_read;
   logic        new_sample;
   logic        readySignal;
   logic [23:0] in_l;
   logic [23:0] in_r;
   logic [23:0] out_l;
   logic [23:0] out_r;
   logic        writeComplete;
   logic [6:0]  some_data;
   logic        signalA;
   logic        signalB;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   audio_manip dut (
      .clk           (clk),
      .rst           (rst),
      .start_write   (start_write),
      .start_read    (start_read),
      .new_sample    (new_sample),
      .readySignal   (readySignal),
      .in_l          (in_l),
      .in_r          (in_r),
      .out_l         (out_l),
      .out_r         (out_r),
      .writeComplete (writeComplete),
      .some_data     (some_data),
      .signalA       (signalA),
      .signalB       (signalB)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_l(input int a);
      return 24'(a + 1);
   endfunction

   function automatic logic [23:0] exp_r(input int a);
      return 24'h800000 | 24'(a);
   endfunction

   initial begin
      int last_a;
      rst         = 1'b1;
      start_write = 1'b0;
      start_read  = 1'b0;
      new_sample  = 1'b0;
      readySignal = 1'b0;
      in_l        = '0;
      in_r        = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_l", 32'(out_l), 32'h0);
      check("rst_out_r", 32'(out_r), 32'h0);
      check("rst_wc", 32'(writeComplete), 32'h0);
      check("rst_sigA", 32'(signalA), 32'h0);
      check("rst_sigB", 32'(signalB), 32'h0);
      check("rst_ptr", 32'(some_data), 32'h0);

      // Start a recording, then reset in the middle of it.
      start_write = 1'b1;
      tick();
      check("mid_sigA", 32'(signalA), 32'h1);
      for (int i = 0; i < 5; i++) begin
         in_l = 24'h00ABCD;
         in_r = 24'h00DCBA;
         new_sample = 1'b1;
         tick();
         new_sample = 1'b0;
         tick();
      end
      check("mid_ptr", 32'(some_data), 32'h5);
      start_write = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("abort_sigA", 32'(signalA), 32'h0);
      check("abort_sigB", 32'(signalB), 32'h0);
      check("abort_ptr", 32'(some_data), 32'h0);
      check("abort_wc", 32'(writeComplete), 32'h0);
      check("abort_out_l", 32'(out_l), 32'h0);
      check("abort_out_r", 32'(out_r), 32'h0);

      // Both triggers high in IDLE: write wins. start_read stays high as an
      // early request that must be ignored until recording completes.
      start_write = 1'b1;
      start_read  = 1'b1;
      tick();
      check("both_sigA", 32'(signalA), 32'h1);
      check("both_sigB", 32'(signalB), 32'h0);
      start_write = 1'b0;
      for (int i = 0; i < 128; i++) begin
         check("rec_ptr", 32'(some_data), 32'(i));
         in_l = exp_l(i);
         in_r = exp_r(i);
         new_sample = 1'b1;
         tick();
         if (i < 127) begin
            check("rec_ptr_inc", 32'(some_data), 32'(i + 1));
            check("rec_wc_low", 32'(writeComplete), 32'h0);
            check("rec_sigA", 32'(signalA), 32'h1);
            check("rec_sigB", 32'(signalB), 32'h0);
         end else begin
            check("rec_ptr_wrap", 32'(some_data), 32'h0);
            check("rec_wc_high", 32'(writeComplete), 32'h1);
            check("rec_sigA_fall", 32'(signalA), 32'h0);
            check("rec_sigB_done", 32'(signalB), 32'h0);
         end
         new_sample = 1'b0;
         tick();
      end
      // The held read request entered READ on the tick after DONE.
      check("read_sigB", 32'(signalB), 32'h1);
      check("read_sigA", 32'(signalA), 32'h0);
      check("read_ptr", 32'(some_data), 32'h0);
      check("rec_out_l_hold", 32'(out_l), 32'h0);
      check("rec_out_r_hold", 32'(out_r), 32'h0);

      // Stalled playback: sample events with readySignal low are dropped.
      in_l = 24'h5A5A5A;
      in_r = 24'hA5A5A5;
      for (int i = 0; i < 50; i++) begin
         new_sample = 1'b1;
         tick();
         new_sample = 1'b0;
         tick();
      end
      check("stall_ptr", 32'(some_data), 32'h0);
      check("stall_out_l", 32'(out_l), 32'h0);
      check("stall_out_r", 32'(out_r), 32'h0);
      check("stall_sigB", 32'(signalB), 32'h1);

      // Looping playback: fetch p lands two edges after its accepting edge,
      // i.e. on the accepting edge of fetch p+1.
      readySignal = 1'b1;
      for (int p = 0; p < 260; p++) begin
         new_sample = 1'b1;
         tick();
         check("play_ptr", 32'(some_data), 32'((p + 1) % 128));
         if (p >= 1) begin
            check("play_out_l", 32'(out_l), 32'(exp_l((p - 1) % 128)));
            check("play_out_r", 32'(out_r), 32'(exp_r((p - 1) % 128)));
         end
         new_sample = 1'b0;
         tick();
         if (p == 0) begin
            check("play_lat_l", 32'(out_l), 32'h0);
            check("play_lat_r", 32'(out_r), 32'h0);
         end else begin
            check("play_hold_l", 32'(out_l), 32'(exp_l((p - 1) % 128)));
         end
      end

      // Drop the read request with fetch 259 in flight: it still lands.
      last_a = 259 % 128;
      start_read = 1'b0;
      tick();
      check("drop_sigB", 32'(signalB), 32'h0);
      check("drop_sigA", 32'(signalA), 32'h0);
      check("drop_wc", 32'(writeComplete), 32'h1);
      check("drop_out_l", 32'(out_l), 32'(exp_l(last_a)));
      check("drop_out_r", 32'(out_r), 32'(exp_r(last_a)));
      for (int i = 0; i < 4; i++) begin
         new_sample = 1'b1;
         tick();
         new_sample = 1'b0;
         tick();
      end
      check("done_hold_l", 32'(out_l), 32'(exp_l(last_a)));
      check("done_hold_r", 32'(out_r), 32'(exp_r(last_a)));
      check("done_ptr", 32'(some_data), 32'(last_a + 1));

      // Re-record from DONE clears writeComplete.
      start_write = 1'b1;
      tick();
      check("rerec_sigA", 32'(signalA), 32'h1);
      check("rerec_wc", 32'(writeComplete), 32'h0);
      check("rerec_ptr", 32'(some_data), 32'h0);
      check("rerec_out_hold", 32'(out_l), 32'(exp_l(last_a)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
